lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_delay_cnt.sv | 28 ++
 rtl/lcd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD init/write sequencer.
// AUTO_WRAP_EN adds the WRAP_WR state used for automatic line wrapping.
package lcd_pkg;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LINE_LEN = 16;
  localparam logic [2:0]  INIT_LAST = 3'd5;

  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;
  localparam logic [7:0] LINE0_ADDR = 8'h80;
  localparam logic [7:0] LINE1_ADDR = 8'hC0;

`ifdef AUTO_WRAP_EN
  typedef enum logic [3:0] {
    StPwrup, StInitWr, StInitHold, StInitWait, StIdle, StWr, StHold, StWait, StWrapWr
  } state_e;
`else
  typedef enum logic [3:0] {
    StPwrup, StInitWr, StInitHold, StInitWait, StIdle, StWr, StHold, StWait
  } state_e;
`endif

  // 8-bit bus, 2 lines, display on, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = 8'h38;
      3'd3:             b = 8'h0C;
      3'd4:             b = CLEAR;
      3'd5:             b = 8'h06;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear and return-home (0x02/0x03) need the longer settle time.
  function automatic logic long_wait(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR || data == HOME || data == (HOME | 8'h01));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with zero flag; stops at zero.
module lcd_delay_cnt
  import lcd_pkg::*;
#(
  parameter int unsigned Width = CNT_W
) (
  input  logic             clk_1ms,
  input  logic             reset_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780-style power-up/init sequencer and request arbiter for a write-cycle engine.
// Define AUTO_WRAP_EN to track the cursor column and auto-issue line-change commands.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_MS = 20,
  parameter int unsigned CLR_MS   = 2,
  parameter int unsigned CMD_MS   = 1
) (
  input  logic       clk_1ms,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       wr_enable,
  output logic       reg_sel,
  output logic [7:0] lcd_data,
  input  logic       wr_finish
);

  // The WAIT states leave on the zero-count cycle, so N ticks load N-1.
  localparam logic [CNT_W-1:0] PwrupLoad = CNT_W'(PWRUP_MS - 1);
  localparam logic [CNT_W-1:0] ClrLoad   = CNT_W'(CLR_MS - 1);
  localparam logic [CNT_W-1:0] CmdLoad   = CNT_W'(CMD_MS - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             armed_q, armed_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
`ifdef AUTO_WRAP_EN
  logic [4:0]       col_q, col_d;
  logic             line_q, line_d;
`endif

  lcd_delay_cnt #(
    .Width(CNT_W)
  ) u_delay (
    .clk_1ms (clk_1ms),
    .reset_n (reset_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  assign req_ready = (state_q == StIdle) && init_done_q;
  assign init_done = init_done_q;
  assign reg_sel   = rs_q;
  assign lcd_data  = data_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    armed_d     = armed_q;
    rs_d        = rs_q;
    data_d      = data_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    wr_enable   = 1'b0;
`ifdef AUTO_WRAP_EN
    col_d       = col_q;
    line_d      = line_q;
`endif
    case (state_q)
      StPwrup: begin
        // First cycle out of reset arms the counter; the zero flag is only trusted after.
        if (!armed_q) begin
          cnt_load = 1'b1;
          cnt_val  = PwrupLoad;
          armed_d  = 1'b1;
        end else if (cnt_zero) begin
          state_d = StInitWr;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          data_d  = init_byte(3'd0);
        end
      end
      StInitWr: begin
        wr_enable = 1'b1;
        state_d   = StInitHold;
      end
      StInitHold: begin
        if (wr_finish) begin
          cnt_load = 1'b1;
          cnt_val  = long_wait(rs_q, data_q) ? ClrLoad : CmdLoad;
          state_d  = StInitWait;
        end
      end
      StInitWait: begin
        if (cnt_zero) begin
          if (idx_q == INIT_LAST) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end else begin
            state_d = StInitWr;
            idx_d   = idx_q + 3'd1;
            data_d  = init_byte(idx_q + 3'd1);
          end
        end
      end
      StIdle: begin
        if (req_valid && req_ready) begin
          state_d = StWr;
          rs_d    = req_rs;
          data_d  = req_data;
`ifdef AUTO_WRAP_EN
          if (req_rs) begin
            col_d = col_q + 5'd1;
          end else if (req_data == CLEAR || req_data == HOME) begin
            col_d  = '0;
            line_d = 1'b0;
          end else if (req_data[7]) begin
            col_d  = req_data[4:0];
            line_d = req_data[6];
          end
`endif
        end
      end
      StWr: begin
        wr_enable = 1'b1;
        state_d   = StHold;
      end
      StHold: begin
        if (wr_finish) begin
          cnt_load = 1'b1;
          cnt_val  = long_wait(rs_q, data_q) ? ClrLoad : CmdLoad;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_zero) begin
`ifdef AUTO_WRAP_EN
          if (rs_q && col_q >= 5'(LINE_LEN)) begin
            state_d = StWrapWr;
            rs_d    = 1'b0;
            data_d  = line_q ? LINE0_ADDR : LINE1_ADDR;
            col_d   = '0;
            line_d  = ~line_q;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef AUTO_WRAP_EN
      StWrapWr: begin
        wr_enable = 1'b1;
        state_d   = StHold;
      end
`endif
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPwrup;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      armed_q     <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
`ifdef AUTO_WRAP_EN
      col_q       <= '0;
      line_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      armed_q     <= armed_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
`ifdef AUTO_WRAP_EN
      col_q       <= col_d;
      line_q      <= line_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed self-checking bench for lcd_sequencer; stand-in write engine answers
// each wr_enable with a one-cycle wr_finish in the following cycle.
module tb_lcd_sequencer;

  logic       clk_1ms = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       wr_enable;
  logic       reg_sel;
  logic [7:0] lcd_data;
  logic       wr_finish = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] init_rom [6];

  lcd_sequencer #(
    .PWRUP_MS(20),
    .CLR_MS  (2),
    .CMD_MS  (1)
  ) dut (
    .clk_1ms  (clk_1ms),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .init_done(init_done),
    .wr_enable(wr_enable),
    .reg_sel  (reg_sel),
    .lcd_data (lcd_data),
    .wr_finish(wr_finish)
  );

  always #5 clk_1ms = ~clk_1ms;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_1ms);
  endtask

  task automatic wait_we(input int max, output int waited);
    waited = 0;
    while (wr_enable !== 1'b1 && waited < max) begin
      tick();
      waited++;
    end
  endtask

  task automatic wait_ready(input int max, output int waited);
    waited = 0;
    while (req_ready !== 1'b1 && waited < max) begin
      tick();
      waited++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    wr_enable, 0);
    check({tag, "_rs"},    reg_sel,   0);
    check({tag, "_data"},  lcd_data,  8'h00);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_done"},  init_done, 0);
  endtask

  // Called on the wr_enable cycle; returns on the first WAIT cycle.
  task automatic service_write(input logic [7:0] exp_data, input logic exp_rs, input string tag);
    check({tag, "_data"}, lcd_data, exp_data);
    check({tag, "_rs"},   reg_sel,  exp_rs);
    tick();
    check({tag, "_we_pulse"}, wr_enable, 0);
    check({tag, "_hold"},     lcd_data,  exp_data);
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
    check({tag, "_after_fin"}, lcd_data, exp_data);
    check({tag, "_rs_after"},  reg_sel,  exp_rs);
  endtask

  task automatic send_nowait(input logic rs, input logic [7:0] data, input string tag);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_rs    = ~rs;
    req_data  = 8'hA5;
    check({tag, "_latency"}, wr_enable, 1);
    service_write(data, rs, tag);
  endtask

  task automatic send(input logic rs, input logic [7:0] data, input string tag, input int exp_wait);
    int w;
    send_nowait(rs, data, tag);
    wait_ready(8, w);
    check({tag, "_wait"}, w, exp_wait);
  endtask

  // Starts on the cycle reset_n is released; ends on the first IDLE cycle.
  task automatic run_init(input logic with_req);
    int w;
    repeat (5) tick();
    if (with_req) begin
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h41;
    end
    // One arming cycle plus 20 counted ticks: first write on cycle 21.
    wait_we(40, w);
    check("pwrup_ticks", w, 16);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        wait_we(6, w);
        check("init_gap", w, (i == 5) ? 2 : 1);
      end
      check("init_we", wr_enable, 1);
      check("init_ready_low", req_ready, 0);
      check("init_done_low", init_done, 0);
      service_write(init_rom[i], 1'b0, "init");
    end
    tick();
    check("init_done_high", init_done, 1);
    check("init_ready_high", req_ready, 1);
  endtask

  initial begin
    int w;
    init_rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;

    // Power-up with a request held from tick 5; it must be written exactly once after init.
    run_init(1'b1);
    tick();
    req_valid = 1'b0;
    check("early_we", wr_enable, 1);
    service_write(8'h41, 1'b1, "early");
    wait_ready(8, w);
    check("early_wait", w, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("early_no_dup", wr_enable, 0);
    end

    // Stray wr_finish while idle must do nothing.
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
    check("stray_fin_we", wr_enable, 0);
    check("stray_fin_ready", req_ready, 1);
    tick();
    check("stray_fin_ready2", req_ready, 1);

    send(1'b1, 8'h48, "data", 1);
    send(1'b0, 8'h01, "clear", 2);

`ifdef AUTO_WRAP_EN
    for (int i = 0; i < 15; i++) send(1'b1, 8'(8'h61 + i), "col", 1);
    send_nowait(1'b1, 8'h70, "col16");
    wait_we(4, w);
    check("wrap_gap", w, 1);
    check("wrap_ready_low", req_ready, 0);
    service_write(8'hC0, 1'b0, "wrap");
    wait_ready(8, w);
    check("wrap_wait", w, 1);
    send(1'b1, 8'h71, "col17", 1);
`else
    for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h61 + i), "col", 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nowrap_idle_we", wr_enable, 0);
    end
`endif

    // Reset while in HOLD: outputs clear immediately, full init reruns.
    check("mid_ready", req_ready, 1);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    tick();
    req_valid = 1'b0;
    check("mid_we", wr_enable, 1);
    tick();
    check("mid_hold_data", lcd_data, 8'h5A);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    tick();
    check_reset_vals("mid_reset_held");
    reset_n = 1'b1;
    run_init(1'b0);
    send(1'b1, 8'h42, "post_reset", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
